memory_1: RTL and testbench



---
 rtl/memory_1_pkg.sv | 16 +
 rtl/memory_1_if.sv | 24 ++
 rtl/memory_1_array.sv | 49 ++++
 rtl/memory_1.sv | 63 ++++++
 tb/tb_memory_1.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/memory_1_pkg.sv
// Shared constants and types for the memory_1 scratch store.
package memory_1_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Encoding of rd_wr_i
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

endpackage

// File: rtl/memory_1_if.sv
// Request/response bus between a simple master and the memory_1 scratch store.
interface memory_1_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) ();

  logic                  valid_i;
  logic                  ready_o;
  logic                  rd_wr_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [WIDTH-1:0]      rdata_o;
  logic [WIDTH-1:0]      wdata_i;

  modport master (
    output valid_i, rd_wr_i, addr_i, wdata_i,
    input  ready_o, rdata_o
  );

  modport slave (
    input  valid_i, rd_wr_i, addr_i, wdata_i,
    output ready_o, rdata_o
  );

endinterface

// File: rtl/memory_1_array.sv
// Word storage with registered read port for memory_1.
// With MEMORY_1_CLEAR_ON_RESET_EN defined, reset also clears every entry.
module memory_1_array #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic                  rd_ok_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

`ifdef MEMORY_1_CLEAR_ON_RESET_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end
`else
  // No reset on storage so the array can map onto RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end
`endif

  // Out-of-range reads return zeros rather than whatever the index aliases to.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = rd_ok_i ? mem_q[addr_i] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_1.sv
// Single-port register-file memory with valid/ready request handshake.
// Optional MEMORY_1_CLEAR_ON_RESET_EN clears contents on reset.
module memory_1
  import memory_1_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  memory_1_if.slave  bus
);

  state_e state_d, state_q;
  logic   ready;
  logic   xfer;
  logic   in_range;
  logic   we, re;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // Leaves RESET on the first edge after release and never returns without reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_RESET;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    if (state_q == ST_READY) ready = 1'b1;
  end

  assign xfer     = bus.valid_i && ready;
  assign in_range = int'(bus.addr_i) < DEPTH;
  assign we       = xfer && (bus.rd_wr_i == WR) && in_range;
  assign re       = xfer && (bus.rd_wr_i == RD);

  assign bus.ready_o = ready;

  memory_1_array #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (we),
    .re_i    (re),
    .rd_ok_i (in_range),
    .addr_i  (bus.addr_i),
    .wdata_i (bus.wdata_i),
    .rdata_o (bus.rdata_o)
  );

endmodule

// File: tb/tb_memory_1.sv
// Directed bench for memory_1: default DEPTH=16 instance plus a DEPTH=12 instance.
module tb_memory_1;

  logic clk;
  logic rst_n;

  int n_chk;
  int n_bad;

  memory_1_if #(.WIDTH(8), .ADDR_WIDTH(4)) b16 ();
  memory_1_if #(.WIDTH(8), .ADDR_WIDTH(4)) b12 ();

  memory_1 #(.WIDTH(8), .DEPTH(16)) dut16 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (b16.slave)
  );

  memory_1 #(.WIDTH(8), .DEPTH(12)) dut12 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (b12.slave)
  );

  // Posedges at 10, 20, 30 ...; 25 ns lands between edges.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle on the 16-deep bus; returns #1 after the edge.
  task automatic xfer16(input logic v, input logic wr, input logic [3:0] a, input logic [7:0] d);
    b16.valid_i = v;
    b16.rd_wr_i = wr;
    b16.addr_i  = a;
    b16.wdata_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic xfer12(input logic v, input logic wr, input logic [3:0] a, input logic [7:0] d);
    b12.valid_i = v;
    b12.rd_wr_i = wr;
    b12.addr_i  = a;
    b12.wdata_i = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_after_rst;

  initial begin
    n_chk = 0;
    n_bad = 0;
    b16.valid_i = 1'b0; b16.rd_wr_i = 1'b0; b16.addr_i = '0; b16.wdata_i = '0;
    b12.valid_i = 1'b0; b12.rd_wr_i = 1'b0; b12.addr_i = '0; b12.wdata_i = '0;

    // Reset held 0..25 ns
    rst_n = 1'b0;
    #12;
    check_eq("rst_ready", 32'(b16.ready_o), 32'h0);
    check_eq("rst_rdata", 32'(b16.rdata_o), 32'h0);
    #13;
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready_before_edge", 32'(b16.ready_o), 32'h0);
    @(posedge clk);
    #1;
    check_eq("ready_after_edge", 32'(b16.ready_o), 32'h1);
    check_eq("ready12_after_edge", 32'(b12.ready_o), 32'h1);

    // Fill then read back
    for (int i = 0; i < 16; i++) xfer16(1'b1, 1'b1, 4'(i), 8'hA0 + 8'(i));
    for (int i = 0; i < 16; i++) begin
      xfer16(1'b1, 1'b0, 4'(i), 8'h00);
      check_eq($sformatf("fill_rd%0d", i), 32'(b16.rdata_o), 32'(8'hA0 + 8'(i)));
    end

    // Gated write must not land; rdata holds across idle
    xfer16(1'b0, 1'b1, 4'd3, 8'h55);
    check_eq("idle_hold", 32'(b16.rdata_o), 32'hAF);
    xfer16(1'b1, 1'b0, 4'd3, 8'h00);
    check_eq("gated_wr", 32'(b16.rdata_o), 32'hA3);

    // Write holds rdata; read-after-write sees new data
    xfer16(1'b1, 1'b1, 4'd7, 8'h3C);
    check_eq("wr_hold", 32'(b16.rdata_o), 32'hA3);
    xfer16(1'b1, 1'b0, 4'd7, 8'h00);
    check_eq("raw", 32'(b16.rdata_o), 32'h3C);

    // Mid-operation reset during a write stream
    xfer16(1'b1, 1'b1, 4'd0, 8'h11);
    xfer16(1'b1, 1'b0, 4'd1, 8'h00);
    check_eq("pre_rst_rd", 32'(b16.rdata_o), 32'hA1);
    b16.valid_i = 1'b1; b16.rd_wr_i = 1'b1; b16.addr_i = 4'd0; b16.wdata_i = 8'h22;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(b16.ready_o), 32'h0);
    check_eq("mid_rst_rdata", 32'(b16.rdata_o), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_ready_back", 32'(b16.ready_o), 32'h1);
    xfer16(1'b1, 1'b0, 4'd0, 8'h00);
`ifdef MEMORY_1_CLEAR_ON_RESET_EN
    exp_after_rst = 8'h00;
`else
    exp_after_rst = 8'h11;
`endif
    check_eq("post_rst_rd0", 32'(b16.rdata_o), 32'(exp_after_rst));
    xfer16(1'b0, 1'b0, 4'd0, 8'h00);

    // DEPTH=12: out-of-range write dropped, read returns zero
    xfer12(1'b1, 1'b1, 4'd4, 8'h44);
    xfer12(1'b1, 1'b0, 4'd4, 8'h00);
    check_eq("d12_rd4", 32'(b12.rdata_o), 32'h44);
    xfer12(1'b1, 1'b1, 4'd13, 8'hFF);
    check_eq("d12_oor_wr_ready", 32'(b12.ready_o), 32'h1);
    xfer12(1'b1, 1'b0, 4'd13, 8'h00);
    check_eq("d12_oor_rd", 32'(b12.rdata_o), 32'h00);
    check_eq("d12_oor_ready", 32'(b12.ready_o), 32'h1);
    xfer12(1'b1, 1'b0, 4'd4, 8'h00);
    check_eq("d12_rd4_again", 32'(b12.rdata_o), 32'h44);
    xfer12(1'b0, 1'b0, 4'd0, 8'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
